// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the posted-write store buffer.
package store_buffer_pkg;

  localparam int WORD_LSB  = 2;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  // Owner of the single dmem port for the current cycle.
  typedef enum logic [1:0] {
    GRANT_DRAIN     = 2'd0,
    GRANT_ATOMIC    = 2'd1,
    GRANT_LOAD_HIT  = 2'd2,
    GRANT_LOAD_MISS = 2'd3
  } grant_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Entry storage for the store buffer: circular queue with head/tail/count
// and a parallel word-address lookup that returns the youngest match.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [AW-1:0]        push_adr,
  input  logic [DW-1:0]        push_data,
  input  logic                 pop,
  input  logic [AW-WORD_LSB-1:0] lookup_word,
  output logic [AW-1:0]        head_adr,
  output logic [DW-1:0]        head_data,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 hit,
  output logic [DW-1:0]        hit_data
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AW-1:0]    adr_mem  [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] youngest;
  logic [DW-1:0]    aged_data [DEPTH];

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[tail]  <= push_adr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_adr  = adr_mem[head];
  assign head_data = data_mem[head];
  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));

  // Match vector indexed by age (0 = oldest); the highest set bit wins.
  always_comb begin
    match    = '0;
    youngest = '0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      aged_data[k] = data_mem[head + PW'(k)];
      match[k]     = (CW'(k) < count) &&
                     (adr_mem[head + PW'(k)][AW-1:WORD_LSB] == lookup_word);
    end
    for (int k = 0; k < DEPTH; k++) begin
      youngest[k] = match[k] && ((match >> (k + 1)) == '0);
      hit_data    = hit_data | (aged_data[k] & {DW{youngest[k]}});
    end
    hit = |match;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core and dmem: retires stores in one cycle,
// drains them over the shared port, forwards loads and serialises LL/SC.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_memwrite,
  input  logic                   cpu_memread,
  input  logic                   cpu_atomic,
  input  logic [AW-1:0]          cpu_adr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_stall,
  output logic                   mem_write,
  output logic                   mem_atomic,
  output logic [AW-1:0]          mem_adr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   mem_ready,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  logic          push;
  logic          pop;
  logic          port_free;
  logic          atomic_req;
  logic          full;
  logic          empty;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [AW-1:0] head_adr;
  logic [DW-1:0] head_data;
  grant_t        grant;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_adr    (cpu_adr),
    .push_data   (cpu_wdata),
    .pop         (pop),
    .lookup_word (cpu_adr[AW-1:WORD_LSB]),
    .head_adr    (head_adr),
    .head_data   (head_data),
    .count       (sb_count),
    .empty       (empty),
    .full        (full),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  assign sb_empty   = empty;
  assign atomic_req = cpu_atomic & (cpu_memread | cpu_memwrite);

  // Port priority: atomic, then load hit, then load miss, otherwise drain.
  always_comb begin
    grant = GRANT_DRAIN;
    if (atomic_req) begin
      grant = GRANT_ATOMIC;
    end else if (cpu_memread & hit) begin
      grant = GRANT_LOAD_HIT;
    end else if (cpu_memread) begin
      grant = GRANT_LOAD_MISS;
    end else begin
      grant = GRANT_DRAIN;
    end
  end

  // Port muxing, drain/pop and enqueue/stall decisions.
  always_comb begin
    cpu_rdata  = mem_rdata;
    cpu_stall  = 1'b0;
    mem_write  = 1'b0;
    mem_atomic = 1'b0;
    mem_adr    = head_adr;
    mem_wdata  = head_data;
    port_free  = 1'b1;
    pop        = 1'b0;
    push       = 1'b0;

    case (grant)
      GRANT_ATOMIC: begin
        // LL/SC must observe every older store, so wait for the drain.
        if (empty) begin
          mem_adr    = cpu_adr;
          mem_wdata  = cpu_wdata;
          mem_write  = cpu_memwrite;
          mem_atomic = 1'b1;
          port_free  = 1'b0;
        end else begin
          cpu_stall  = 1'b1;
          port_free  = 1'b1;
        end
      end
      GRANT_LOAD_HIT: begin
        cpu_rdata = hit_data;
        port_free = 1'b1;
      end
      GRANT_LOAD_MISS: begin
        mem_adr   = cpu_adr;
        port_free = 1'b0;
      end
      default: begin
        port_free = 1'b1;
      end
    endcase

    if (port_free & ~empty) begin
      mem_adr   = head_adr;
      mem_wdata = head_data;
      mem_write = mem_ready;
      pop       = mem_ready;
    end else begin
      pop       = 1'b0;
    end

    if (cpu_memwrite & ~cpu_atomic) begin
      if (~full | pop) begin
        push = 1'b1;
      end else begin
        cpu_stall = 1'b1;
      end
    end else begin
      push = 1'b0;
    end
  end

endmodule
